// File: rtl/store_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_write_buffer
// Description : Posted-write FIFO between the processor store port and the
//               dmem write port, with youngest-match store-to-load forwarding.
// Revision    : 1.0
// ============================================================================
module store_write_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_write_memory,
  input  logic [ADDR_WIDTH-1:0]      data_address_memory,
  input  logic [DATA_WIDTH-1:0]      write_data_memory,
  output logic                       store_stall,
  input  logic [ADDR_WIDTH-1:0]      load_address,
  output logic                       load_hit,
  output logic [DATA_WIDTH-1:0]      load_data,
  output logic                       dmem_wr_valid,
  output logic [ADDR_WIDTH-1:0]      dmem_wr_addr,
  output logic [DATA_WIDTH-1:0]      dmem_wr_data,
  input  logic                       dmem_wr_ready,
  output logic                       buf_empty,
  output logic [$clog2(DEPTH):0]     buf_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_WIDTH - 2;

  // Only word addresses are kept; byte offsets are dropped on entry.
  logic [WA_W-1:0]       r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;

  logic                  w_drain;
  logic                  w_accept;
  logic                  w_not_full;
  logic                  w_load_hit;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [PTR_W-1:0]      w_fwd_idx;
  logic                  w_unused_addr_lsbs;

  assign w_unused_addr_lsbs = ^{data_address_memory[1:0], load_address[1:0]};

  assign w_not_full = (r_count < CNT_W'(DEPTH));
  assign w_drain    = dmem_wr_valid && dmem_wr_ready;
  assign w_accept   = mem_write_memory && (w_not_full || w_drain);

  assign store_stall   = mem_write_memory && !w_accept;
  assign dmem_wr_valid = (r_count != '0);
  assign dmem_wr_addr  = {r_addr[r_head], 2'b00};
  assign dmem_wr_data  = r_data[r_head];
  assign buf_empty     = (r_count == '0);
  assign buf_count     = r_count;
  assign load_hit      = w_load_hit;
  assign load_data     = w_load_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_drain) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_accept, w_drain})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is qualified by r_count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!reset && w_accept) begin
      r_addr[r_tail] <= data_address_memory[ADDR_WIDTH-1:2];
      r_data[r_tail] <= write_data_memory;
    end
  end

  // Walk entries oldest to youngest so the last match (youngest) wins.
  always_comb begin
    w_load_hit  = 1'b0;
    w_load_data = '0;
    w_fwd_idx   = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_fwd_idx = r_head + PTR_W'(i);
      if ((CNT_W'(i) < r_count) &&
          (r_addr[w_fwd_idx] == load_address[ADDR_WIDTH-1:2])) begin
        w_load_hit  = 1'b1;
        w_load_data = r_data[w_fwd_idx];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_write_buffer
// Description : Directed + random scoreboard bench for store_write_buffer.
// Revision    : 1.0
// ============================================================================
module tb_store_write_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  logic        clk;
  logic        reset;
  logic        mem_write_memory;
  logic [31:0] data_address_memory;
  logic [31:0] write_data_memory;
  logic        store_stall;
  logic [31:0] load_address;
  logic        load_hit;
  logic [31:0] load_data;
  logic        dmem_wr_valid;
  logic [31:0] dmem_wr_addr;
  logic [31:0] dmem_wr_data;
  logic        dmem_wr_ready;
  logic        buf_empty;
  logic [2:0]  buf_count;

  int   n_cmp;
  int   n_fail;
  ent_t q[$];

  store_write_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .mem_write_memory    (mem_write_memory),
    .data_address_memory (data_address_memory),
    .write_data_memory   (write_data_memory),
    .store_stall         (store_stall),
    .load_address        (load_address),
    .load_hit            (load_hit),
    .load_data           (load_data),
    .dmem_wr_valid       (dmem_wr_valid),
    .dmem_wr_addr        (dmem_wr_addr),
    .dmem_wr_data        (dmem_wr_data),
    .dmem_wr_ready       (dmem_wr_ready),
    .buf_empty           (buf_empty),
    .buf_count           (buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check all outputs against the queue model
  // mid-cycle, then advance the model across the rising edge.
  task automatic step(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic rdy, input logic [31:0] la, input logic rst);
    logic        e_drain;
    logic        e_acc;
    logic        e_hit;
    logic [31:0] e_ld;
    ent_t        e;
    mem_write_memory    = wr;
    data_address_memory = addr;
    write_data_memory   = data;
    dmem_wr_ready       = rdy;
    load_address        = la;
    reset               = rst;
    @(negedge clk);
    e_drain = (q.size() != 0) && rdy;
    e_acc   = wr && ((q.size() < DEPTH) || e_drain);
    e_hit   = 1'b0;
    e_ld    = '0;
    foreach (q[i]) begin
      if (q[i].a[31:2] == la[31:2]) begin
        e_hit = 1'b1;
        e_ld  = q[i].d;
      end
    end
    chk("store_stall", 64'(store_stall), 64'(wr && !e_acc));
    chk("dmem_wr_valid", 64'(dmem_wr_valid), 64'(q.size() != 0));
    chk("buf_count", 64'(buf_count), 64'(q.size()));
    chk("buf_empty", 64'(buf_empty), 64'(q.size() == 0));
    chk("load_hit", 64'(load_hit), 64'(e_hit));
    chk("load_data", 64'(load_data), 64'(e_ld));
    if (q.size() != 0) begin
      chk("dmem_wr_addr", 64'(dmem_wr_addr), 64'(q[0].a & 32'hFFFF_FFFC));
      chk("dmem_wr_data", 64'(dmem_wr_data), 64'(q[0].d));
    end
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
    end else begin
      if (e_drain) void'(q.pop_front());
      if (e_acc) begin
        e.a = addr;
        e.d = data;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic rdy, input logic [31:0] la);
    step(1'b0, 32'h0, 32'h0, rdy, la, 1'b0);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset               = 1'b1;
    mem_write_memory    = 1'b0;
    data_address_memory = '0;
    write_data_memory   = '0;
    dmem_wr_ready       = 1'b0;
    load_address        = '0;
    @(posedge clk);
    #1;
    step(1'b0, 0, 0, 1'b0, 0, 1'b1);

    // Reset state
    @(negedge clk);
    chk("rst_valid", 64'(dmem_wr_valid), 64'd0);
    chk("rst_empty", 64'(buf_empty), 64'd1);
    chk("rst_count", 64'(buf_count), 64'd0);
    chk("rst_hit", 64'(load_hit), 64'd0);
    chk("rst_ldata", 64'(load_data), 64'd0);
    @(posedge clk);
    #1;

    // Single store, ready=1
    step(1'b1, 32'h0, 32'h8, 1'b1, 32'h100, 1'b0);
    mem_write_memory = 1'b0;
    @(negedge clk);
    chk("single_valid", 64'(dmem_wr_valid), 64'd1);
    chk("single_addr", 64'(dmem_wr_addr), 64'h0);
    chk("single_data", 64'(dmem_wr_data), 64'h8);
    @(posedge clk);
    #1;
    void'(q.pop_front());
    idle(1'b1, 32'h100);
    chk("single_drained_empty", 64'(buf_empty), 64'd1);

    // Fill and stall, then release
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 32'(32'hA0 + i), 1'b0, 32'h4, 1'b0);
    step(1'b1, 32'h10, 32'hA4, 1'b0, 32'h10, 1'b0);
    chk("fill_count", 64'(buf_count), 64'd4);
    step(1'b1, 32'h10, 32'hA4, 1'b1, 32'h10, 1'b0);
    for (int i = 0; i < 6; i++) idle(1'b1, 32'hC);

    // Forwarding, youngest wins
    step(1'b1, 32'h20, 32'h1111_1111, 1'b0, 32'h20, 1'b0);
    step(1'b1, 32'h20, 32'h2222_2222, 1'b0, 32'h20, 1'b0);
    idle(1'b0, 32'h20);
    mem_write_memory = 1'b0;
    load_address = 32'h23;
    #1;
    chk("fwd_word_hit", 64'(load_hit), 64'd1);
    chk("fwd_word_data", 64'(load_data), 64'h2222_2222);
    load_address = 32'h24;
    #1;
    chk("fwd_miss_hit", 64'(load_hit), 64'd0);
    chk("fwd_miss_data", 64'(load_data), 64'd0);
    idle(1'b0, 32'h23);
    idle(1'b1, 32'h20);
    idle(1'b1, 32'h20);

    // Back-pressure stability
    step(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, 32'h40, 1'b0);
    idle(1'b0, 32'h40);
    idle(1'b0, 32'h40);
    idle(1'b1, 32'h40);
    chk("bp_drained", 64'(buf_empty), 64'd1);

    // Full with simultaneous accept and drain, three wraps
    for (int i = 0; i < 4; i++) step(1'b1, 32'(32'h80 + i * 4), 32'(32'hB00 + i), 1'b0, 32'h84, 1'b0);
    for (int i = 0; i < 3 * DEPTH; i++)
      step(1'b1, 32'(32'h90 + (i % 6) * 4), 32'(32'hC00 + i), 1'b1, 32'(32'h90 + (i % 5) * 4), 1'b0);
    chk("wrap_full_count", 64'(buf_count), 64'd4);
    for (int i = 0; i < 5; i++) idle(1'b1, 32'h94);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) step(1'b1, 32'(32'h8 + i * 4), 32'(32'hE0 + i), 1'b0, 32'h8, 1'b0);
    step(1'b0, 0, 0, 1'b0, 32'h8, 1'b1);
    idle(1'b1, 32'h8);
    chk("midrst_count", 64'(buf_count), 64'd0);
    step(1'b1, 32'h8, 32'h5, 1'b1, 32'h8, 1'b0);
    idle(1'b1, 32'h8);
    idle(1'b1, 32'h8);

    // Random traffic
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), {26'h0, 6'($urandom_range(0, 63))}, $urandom,
           1'($urandom_range(0, 2) != 0), {26'h0, 6'($urandom_range(0, 63))},
           1'($urandom_range(0, 60) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Posted-write FIFO between the mips processor's data-memory port (mem_write_memory / data_address_memory / write_data_memory) and dmem's write port.
- Absorbs processor stores in one cycle and drains them to dmem under a valid/ready handshake.
- Stalls the processor only when full.
- Forwards buffered store data to loads (youngest match wins), so SW followed by LW to the same word returns the stored value before dmem is updated.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- ADDR_WIDTH, 32, byte-address width
- DATA_WIDTH, 32, store data width (word stores only)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- mem_write_memory  input  1  processor store request
- data_address_memory  input  ADDR_WIDTH  store byte address
- write_data_memory  input  DATA_WIDTH  store data
- store_stall  output  1  store not accepted this cycle; processor must hold request
- load_address  input  ADDR_WIDTH  address of current processor load
- load_hit  output  1  load_address word-matches a buffered entry
- load_data  output  DATA_WIDTH  data of youngest matching entry; 0 when no hit
- dmem_wr_valid  output  1  head entry presented to dmem
- dmem_wr_addr  output  ADDR_WIDTH  head address, bits [1:0] forced to 0
- dmem_wr_data  output  DATA_WIDTH  head data
- dmem_wr_ready  input  1  dmem accepts head this cycle
- buf_empty  output  1  no entries held
- buf_count  output  $clog2(DEPTH)+1  entries held

Behaviour:
- Storage:
  - Circular array with head (oldest) pointer, tail pointer, and count register.
  - Pointers wrap modulo DEPTH.
- Drain (drain_fire):
  - drain_fire = dmem_wr_valid && dmem_wr_ready.
  - On fire, head advances and count decrements.
- Accept:
  - accept = mem_write_memory && (count < DEPTH || drain_fire).
  - On accept, entry written at tail; tail advances; count increments.
  - Accept and drain in the same cycle: count unchanged.
- Stall:
  - store_stall = mem_write_memory && !accept (combinational).
  - Never asserted when mem_write_memory = 0.
  - Full with dmem_wr_ready = 1: no stall (slot frees this cycle).
- dmem handshake:
  - dmem_wr_valid = (count != 0).
  - While valid and not ready, addr and data must hold stable.
  - Entries drain strictly in acceptance order; no reordering, no coalescing.
- Latency:
  - Store accepted at edge N into an empty buffer appears on dmem_wr_* in the cycle after edge N.
  - Minimum store-to-dmem latency is 1 cycle; throughput is 1 store/cycle when dmem_wr_ready is held high.
- Forwarding:
  - Purely combinational over valid entries.
  - Compare load_address[ADDR_WIDTH-1:2] against stored address[ADDR_WIDTH-1:2].
  - Multiple matches: the youngest (closest to tail) supplies load_data.
  - The head entry being drained this cycle still participates.
  - The store being accepted this cycle is not visible until the next cycle (no input bypass).
- Reset:
  - Reset values: head = tail = count = 0; dmem_wr_valid = 0; buf_empty = 1; buf_count = 0; load_hit = 0; load_data = 0.
  - Asserting reset mid-operation discards all held entries; no further dmem writes until new stores arrive.
  - Storage array contents need not be reset (qualified by count).
  - Reset has priority over accept and drain in the same cycle.
- Width and invalid-input rules:
  - buf_count never exceeds DEPTH.
  - Behaviour when X on inputs while reset is high is don't-care.

Test Plan:
- Single store, ready=1: reset, then one store, addr 0x00000000 data 0x00000008 → next cycle dmem_wr_valid=1, addr 0x0, data 0x8; following cycle buf_empty=1.
- Fill and stall: ready=0; 5 consecutive stores to 0x0,0x4,0x8,0xC,0x10 → first 4 accepted, buf_count=4, store_stall=1 on the 5th. Raise ready → 5th accepted same cycle; drain order 0x0,0x4,0x8,0xC,0x10.
- Forwarding youngest wins: ready=0; stores 0x20←0x11111111, then 0x20←0x22222222 → load_address 0x20 gives load_hit=1, load_data 0x22222222. Load_address 0x23 also hits (word match). Load_address 0x24 gives load_hit=0, load_data=0.
- Back-pressure stability: ready toggled 0,0,1 with one entry 0x40←0xDEADBEEF → addr/data unchanged across both stalled cycles, drains on the third.
- Full with simultaneous accept and drain: buffer full, ready=1, store presented → no stall, buf_count stays 4, pointers wrap correctly over 3 full DEPTH cycles.
- Reset mid-operation: 3 entries held, reset pulsed 1 cycle → buf_count=0, dmem_wr_valid=0, load_hit=0 next cycle; subsequent store 0x8←0x5 drains normally.
